// File: rtl/rsa_message_sequencer_pkg.sv
// Shared types for the RSA message sequencer: FSM state encoding and the
// input FIFO entry layout.
package rsa_message_sequencer_pkg;

  // Symbol width carried in a FIFO entry; the sequencer's MSG_WIDTH must match.
  localparam int SYM_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic                 last;
    logic [SYM_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; depth must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and count, so resetting the array would only cost area.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rsa_message_sequencer.sv
// Buffers message symbols, holds the active key, issues one engine operation
// at a time and presents each result on a ready/valid ciphertext port.
module rsa_message_sequencer
  import rsa_message_sequencer_pkg::*;
#(
  parameter int MSG_WIDTH  = SYM_WIDTH,
  parameter int KEY_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 key_load_in,
  input  logic [KEY_WIDTH-1:0] exponent_in,
  input  logic [KEY_WIDTH-1:0] modulus_in,
  output logic                 key_ack_out,
  input  logic [MSG_WIDTH-1:0] byte_in,
  input  logic                 byte_last_in,
  input  logic                 byte_valid_in,
  output logic                 byte_ready_out,
  output logic                 eng_ready_out,
  output logic [MSG_WIDTH-1:0] eng_value_out,
  output logic [KEY_WIDTH-1:0] eng_exponent_out,
  output logic [KEY_WIDTH-1:0] eng_modulus_out,
  input  logic                 eng_busy_in,
  input  logic                 eng_valid_in,
  input  logic [KEY_WIDTH-1:0] eng_result_in,
  output logic [KEY_WIDTH-1:0] cipher_out,
  output logic                 cipher_last_out,
  output logic                 cipher_valid_out,
  input  logic                 cipher_ready_in
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t  state;
  fifo_entry_t push_entry;
  fifo_entry_t head_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        push;
  logic        pop;
  logic        key_accept;
  logic        tag_last;

  assign push_entry     = '{last: byte_last_in, data: byte_in};
  assign byte_ready_out = !fifo_full;
  assign push           = byte_valid_in && byte_ready_out;
  assign pop            = (state == ST_IDLE) && !fifo_empty && !eng_busy_in;
  // Keys change only with nothing queued or in flight.
  assign key_accept     = key_load_in && (state == ST_IDLE) && (fifo_count == '0);

  sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst     (rst_in),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= ST_IDLE;
      key_ack_out      <= 1'b0;
      eng_exponent_out <= '0;
      eng_modulus_out  <= '0;
      eng_ready_out    <= 1'b0;
      eng_value_out    <= '0;
      tag_last         <= 1'b0;
      cipher_out       <= '0;
      cipher_last_out  <= 1'b0;
      cipher_valid_out <= 1'b0;
    end else begin
      key_ack_out <= key_accept;
      if (key_accept) begin
        eng_exponent_out <= exponent_in;
        eng_modulus_out  <= modulus_in;
      end
      // NOTE: the default here is overridden by the later assignment in the
      // IDLE branch; with non-blocking semantics the last write wins.
      eng_ready_out <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            eng_value_out <= head_entry.data;
            tag_last      <= head_entry.last;
            eng_ready_out <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (eng_valid_in) begin
            cipher_out       <= eng_result_in;
            cipher_last_out  <= tag_last;
            cipher_valid_out <= 1'b1;
            state            <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cipher_ready_in) begin
            cipher_valid_out <= 1'b0;
            cipher_last_out  <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_message_sequencer.sv
// Directed self-checking bench for rsa_message_sequencer with a behavioural
// modular-exponentiation engine of programmable latency.
module tb_rsa_message_sequencer;

  logic        clk;
  logic        rst;
  logic        key_load;
  logic [15:0] exponent;
  logic [15:0] modulus;
  logic        key_ack;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_valid;
  logic        byte_ready;
  logic        eng_ready;
  logic [7:0]  eng_value;
  logic [15:0] eng_exponent;
  logic [15:0] eng_modulus;
  logic        eng_busy;
  logic        eng_valid;
  logic [15:0] eng_result;
  logic [15:0] cipher;
  logic        cipher_last;
  logic        cipher_valid;
  logic        cipher_ready;

  int checks   = 0;
  int failures = 0;
  int lat      = 20;
  int issue_cnt = 0;
  int ready_low_cycles = 0;
  logic [16:0] q[$];

  rsa_message_sequencer dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .key_load_in      (key_load),
    .exponent_in      (exponent),
    .modulus_in       (modulus),
    .key_ack_out      (key_ack),
    .byte_in          (byte_data),
    .byte_last_in     (byte_last),
    .byte_valid_in    (byte_valid),
    .byte_ready_out   (byte_ready),
    .eng_ready_out    (eng_ready),
    .eng_value_out    (eng_value),
    .eng_exponent_out (eng_exponent),
    .eng_modulus_out  (eng_modulus),
    .eng_busy_in      (eng_busy),
    .eng_valid_in     (eng_valid),
    .eng_result_in    (eng_result),
    .cipher_out       (cipher),
    .cipher_last_out  (cipher_last),
    .cipher_valid_out (cipher_valid),
    .cipher_ready_in  (cipher_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] modexp(input logic [7:0] b, input logic [15:0] e,
                                         input logic [15:0] m);
    logic [31:0] acc;
    acc = 32'd1;
    if (m == 16'd0) return 16'd0;
    for (int i = 0; i < int'(e); i++) acc = (acc * {24'd0, b}) % {16'd0, m};
    return acc[15:0];
  endfunction

  // Behavioural engine: starts on eng_ready, answers lat cycles later.
  initial begin
    int cnt;
    logic [15:0] pend;
    cnt = 0;
    pend = '0;
    eng_busy = 1'b0;
    eng_valid = 1'b0;
    eng_result = '0;
    forever begin
      @(posedge clk);
      #2;
      eng_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_valid  = 1'b1;
          eng_result = pend;
          eng_busy   = 1'b0;
        end
      end else if (eng_ready) begin
        eng_busy = 1'b1;
        cnt      = lat;
        pend     = modexp(eng_value, eng_exponent, eng_modulus);
      end
    end
  end

  always @(negedge clk) begin
    if (eng_ready) issue_cnt++;
    if (cipher_valid && cipher_ready) q.push_back({cipher_last, cipher});
  end

  task automatic push_byte(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    byte_data  = b;
    byte_last  = l;
    byte_valid = 1'b1;
    while (!byte_ready && n < 200) begin
      ready_low_cycles++;
      step();
      n++;
    end
    step();
    byte_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!cipher_valid && n < budget) begin
      step();
      n++;
    end
    check(tag, cipher_valid, 1);
  endtask

  task automatic wait_queue(input int size, input int budget);
    int n;
    n = 0;
    while (q.size() < size && n < budget) begin
      step();
      n++;
    end
    check("queue_size", q.size(), size);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0]  burst_b [6] = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd8, 8'd10};
    logic [15:0] burst_r [6] = '{16'd9, 16'd16, 16'd14, 16'd30, 16'd2, 16'd10};
    logic [15:0] c0;
    int i0;
    logic stable;
    logic ack_seen;
    logic stale_seen;
    logic valid_seen;
    int n;

    rst = 1'b1;
    key_load = 1'b0;
    exponent = '0;
    modulus = '0;
    byte_data = '0;
    byte_last = 1'b0;
    byte_valid = 1'b0;
    cipher_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("rst_byte_ready", byte_ready, 1);
    check("rst_key_ack", key_ack, 0);
    check("rst_eng_ready", eng_ready, 0);
    check("rst_cipher_valid", cipher_valid, 0);
    check("rst_cipher_last", cipher_last, 0);
    check("rst_eng_value", eng_value, 0);
    check("rst_exponent", eng_exponent, 0);
    check("rst_modulus", eng_modulus, 0);
    check("rst_cipher", cipher, 0);

    // Key load while idle
    key_load = 1'b1;
    exponent = 16'd7;
    modulus  = 16'd33;
    step();
    key_load = 1'b0;
    check("key_ack_pulse", key_ack, 1);
    check("key_exponent", eng_exponent, 7);
    check("key_modulus", eng_modulus, 33);
    step();
    check("key_ack_clear", key_ack, 0);

    // Single symbol: 2^7 mod 33 = 29, latency t+2 to eng_ready
    lat = 20;
    i0 = issue_cnt;
    push_byte(8'd2, 1'b1);
    check("issue_t1_low", eng_ready, 0);
    step();
    check("issue_t2_high", eng_ready, 1);
    check("issue_value", eng_value, 2);
    step();
    check("issue_one_cycle", eng_ready, 0);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (eng_valid) break;
      n++;
    end
    check("eng_valid_seen", eng_valid, 1);
    @(posedge clk);
    #1;
    check("result_r1_valid", cipher_valid, 1);
    check("result_value", cipher, 29);
    check("result_last", cipher_last, 1);
    step();
    check("result_handshake", cipher_valid, 0);
    check("single_issue_count", issue_cnt - i0, 1);

    // Burst of six symbols into a four-entry FIFO
    lat = 3;
    q.delete();
    ready_low_cycles = 0;
    for (int i = 0; i < 6; i++) push_byte(burst_b[i], i == 5);
    check("burst_backpressure", ready_low_cycles > 0, 1);
    wait_queue(6, 300);
    for (int i = 0; i < 6; i++)
      check($sformatf("burst_word%0d", i), (i < q.size()) ? q[i] : 17'h1ffff,
            {(i == 5) ? 1'b1 : 1'b0, burst_r[i]});

    // Output stall in HOLD while the FIFO fills
    cipher_ready = 1'b0;
    q.delete();
    push_byte(8'd3, 1'b0);
    wait_valid("hold_wait", 40);
    c0 = cipher;
    i0 = issue_cnt;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        byte_data  = burst_b[i + 1];
        byte_last  = (i == 3);
        byte_valid = 1'b1;
      end else begin
        byte_valid = 1'b0;
      end
      step();
      if (cipher !== c0 || cipher_valid !== 1'b1) stable = 1'b0;
    end
    check("hold_value", c0, 9);
    check("hold_stable", stable, 1);
    check("hold_no_issue", issue_cnt - i0, 0);
    check("hold_fifo_full", byte_ready, 0);
    cipher_ready = 1'b1;
    wait_queue(5, 300);
    for (int i = 0; i < 5; i++)
      check($sformatf("hold_word%0d", i), (i < q.size()) ? q[i] : 17'h1ffff,
            {(i == 4) ? 1'b1 : 1'b0, burst_r[i]});

    // Key load during WAIT is ignored, retry after drain is accepted
    lat = 20;
    push_byte(8'd10, 1'b1);
    repeat (3) step();
    key_load = 1'b1;
    exponent = 16'd3;
    modulus  = 16'd11;
    ack_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      ack_seen |= key_ack;
    end
    key_load = 1'b0;
    step();
    ack_seen |= key_ack;
    check("busy_key_no_ack", ack_seen, 0);
    check("busy_key_exponent", eng_exponent, 7);
    check("busy_key_modulus", eng_modulus, 33);
    wait_valid("busy_key_wait", 40);
    check("busy_key_result", cipher, 10);
    step();
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    check("retry_key_ack", key_ack, 1);
    check("retry_exponent", eng_exponent, 3);
    check("retry_modulus", eng_modulus, 11);

    // Reset during WAIT, then a stale engine result
    lat = 20;
    push_byte(8'd2, 1'b1);
    repeat (4) step();
    i0 = issue_cnt;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("mid_rst_byte_ready", byte_ready, 1);
    check("mid_rst_eng_ready", eng_ready, 0);
    check("mid_rst_cipher_valid", cipher_valid, 0);
    check("mid_rst_cipher_last", cipher_last, 0);
    check("mid_rst_eng_value", eng_value, 0);
    check("mid_rst_exponent", eng_exponent, 0);
    check("mid_rst_modulus", eng_modulus, 0);
    check("mid_rst_cipher", cipher, 0);
    stale_seen = 1'b0;
    valid_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      stale_seen |= eng_valid;
      valid_seen |= cipher_valid;
    end
    check("stale_result_arrived", stale_seen, 1);
    check("stale_result_dropped", valid_seen, 0);
    check("stale_no_issue", issue_cnt - i0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_message_sequencer.md
# rsa_message_sequencer

Front-end stage that feeds the modular-exponentiation engine one message symbol at a time and collects its results. It buffers incoming message bytes in a small FIFO, holds the active key (exponent and modulus), and issues single-cycle start pulses to the engine. It then captures each engine result and presents it on a ready/valid ciphertext output with back-pressure. It sits between the UART/byte source and the downstream transmit path, and drives the engine's `ready_in`/`value_in`/`exponent_in`/`modulus_in`.

## Interface
- `MSG_WIDTH`, default 8: message symbol width.
- `KEY_WIDTH`, default 16: exponent, modulus and result width.
- `FIFO_DEPTH`, default 4: input FIFO entries (power of two, ≥2).

Ports:
- `clk_in`  in  1: the single system clock.
- `rst_in`  in  1: synchronous, active-high reset.
- `key_load_in`  in  1: request to latch a new key.
- `exponent_in`  in  KEY_WIDTH: exponent to latch.
- `modulus_in`  in  KEY_WIDTH: modulus to latch.
- `key_ack_out`  out  1: one-cycle pulse when a key load is accepted.
- `byte_in`  in  MSG_WIDTH: message symbol.
- `byte_last_in`  in  1: marks the final symbol of a message.
- `byte_valid_in`  in  1: `byte_in` is valid.
- `byte_ready_out`  out  1: FIFO not full.
- `eng_ready_out`  out  1: one-cycle engine start pulse.
- `eng_value_out`  out  MSG_WIDTH: symbol sent to the engine.
- `eng_exponent_out`  out  KEY_WIDTH: latched exponent.
- `eng_modulus_out`  out  KEY_WIDTH: latched modulus.
- `eng_busy_in`  in  1: engine busy.
- `eng_valid_in`  in  1: engine result-valid pulse.
- `eng_result_in`  in  KEY_WIDTH: engine result.
- `cipher_out`  out  KEY_WIDTH: ciphertext word.
- `cipher_last_out`  out  1: word carries the last-symbol tag.
- `cipher_valid_out`  out  1: `cipher_out` is valid.
- `cipher_ready_in`  in  1: downstream accepts the word.

## Operation
- FIFO:
  - Each entry stores {last, byte}.
  - A push occurs when `byte_valid_in && byte_ready_out`.
  - `byte_ready_out` = (count < FIFO_DEPTH), computed from the registered count.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Key latch:
  - `key_load_in` is accepted only when the FSM is in IDLE and the FIFO is empty. On acceptance the block latches the exponent and modulus and pulses `key_ack_out`.
  - A `key_load_in` arriving at any other time is ignored, with no ack. The source must retry.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty and `eng_busy_in` = 0, pop the head, register it into `eng_value_out` and the tag register, then go to ISSUE.
  - ISSUE: assert `eng_ready_out` for exactly one cycle, then go to WAIT.
  - WAIT: on `eng_valid_in`, capture `eng_result_in` into `cipher_out`, set `cipher_valid_out`, then go to HOLD. `eng_busy_in` is ignored in this state.
  - HOLD: hold `cipher_out`, `cipher_last_out` and `cipher_valid_out` stable until `cipher_ready_in`. On handshake, clear valid and go to IDLE.
- Key loads are blocked while any symbol is in flight, so the exponent and modulus seen by the engine never change mid-operation.
- `eng_valid_in` outside WAIT is ignored.

## Timing
- Reset values:
  - `byte_ready_out` = 1.
  - `key_ack_out`, `eng_ready_out`, `cipher_valid_out` and `cipher_last_out` = 0.
  - `eng_value_out`, `eng_exponent_out`, `eng_modulus_out` and `cipher_out` = 0.
  - FIFO empty, FSM in IDLE.
- Byte accepted at cycle t (FIFO previously empty, FSM in IDLE):
  - Pop at t+1.
  - `eng_ready_out` high at t+2.
- Result capture: `eng_valid_in` at cycle r gives `cipher_valid_out` high at r+1.
- Throughput: at most one outstanding engine operation.
  - With `cipher_ready_in` held high, the next pop occurs the cycle after the output handshake.
- Reset mid-operation:
  - The FIFO is flushed and the key is cleared.
  - Any engine result that arrives afterwards is dropped.

## Structure
- The shared package holds:
  - the FSM state enum (2-bit);
  - the FIFO entry struct {last, byte}.
- One sub-module, `sync_fifo`: parameterized width and depth, with push/pop/full/empty/count, sharing the same clock and reset.

## Test plan
- Reset, then load key exponent=7 and modulus=33 while idle -> `key_ack_out` pulses; `eng_exponent_out`=7 and `eng_modulus_out`=33.
- Push byte 2 (last=1), with a model engine returning 29 after 20 cycles and `cipher_ready_in`=1 -> `eng_ready_out` pulses once with `eng_value_out`=2; `cipher_out`=29 with `cipher_last_out`=1 for one cycle.
- Push 6 bytes back-to-back with FIFO_DEPTH=4 -> `byte_ready_out` drops after 4 accepted, then resumes; all 6 results emerge in order.
- Hold `cipher_ready_in`=0 for 10 cycles in HOLD -> `cipher_out` is stable, no new `eng_ready_out`, and the FIFO keeps filling up to full.
- Assert `key_load_in` while WAIT is active -> no `key_ack_out`, key unchanged; retry after drain -> accepted.
- Assert `rst_in` during WAIT, then a stale `eng_valid_in` -> all outputs at reset values and no `cipher_valid_out`.
